muldiv_seq: RTL and testbench

Multi-cycle unsigned multiply/divide sequencer for the single-cycle core. It accepts a MULTU or DIVU request and drives one dedicated ALU instance with the add/subtract step of each iteration. It owns the shift, carry and quotient logic and delivers a 64-bit {hi, lo} result. It sits beside the main datapath and is started by the decoder on MULTU/DIVU; the core stalls while busy is high.

---
 rtl/muldiv_seq_pkg.sv | 21 ++
 rtl/muldiv_seq_if.sv | 24 ++
 rtl/muldiv_seq_alu.sv | 25 ++
 rtl/muldiv_seq.sv | 124 ++++++++++++
 tb/tb_muldiv_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq shared definitions.
// Operation codes, FSM states and ALU control codes.
package muldiv_seq_pkg;

    localparam logic MD_OP_MULTU = 1'b0;
    localparam logic MD_OP_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_RUN  = 2'd1,
        MD_ST_DONE = 2'd2
    } md_st_e;

    typedef enum logic [1:0] {
        ALU_C_ADD = 2'd0,
        ALU_C_SUB = 2'd1,
        ALU_C_AND = 2'd2,
        ALU_C_OR  = 2'd3
    } alu_c_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq request/result bundle.
// master drives requests, slave is the sequencer.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq_alu.sv
// Core ALU instance used by the sequencer.
// Pure combinational add/sub/logic unit.
module muldiv_seq_alu
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_c_e           alu_c,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] result
);

    // Select the ALU function
    always_comb begin
        result = '0;
        unique case (alu_c)
            ALU_C_ADD: result = operand1 + operand2;
            ALU_C_SUB: result = operand1 - operand2;
            ALU_C_AND: result = operand1 & operand2;
            ALU_C_OR:  result = operand1 | operand2;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer.
// Shift-add multiply, restoring divide, one ALU.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input logic         clk,
    input logic         rst_n,
    muldiv_seq_if.slave bus
);

    md_st_e             state, state_n;
    logic [WIDTH-1:0]   hi, lo, hi_n, lo_n;
    logic [WIDTH-1:0]   opnd, opnd_n;
    logic               op_q, op_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    alu_c_e             alu_c;
    logic [WIDTH-1:0]   op1, op2, alu_res;
    logic [WIDTH-1:0]   r;
    logic               carry;

    muldiv_seq_alu #(.WIDTH(WIDTH)) u_alu (
        .alu_c    (alu_c),
        .operand1 (op1),
        .operand2 (op2),
        .result   (alu_res)
    );

    assign r        = {hi[WIDTH-2:0], lo[WIDTH-1]};
    assign carry    = alu_res < hi;
    assign bus.busy = (state == MD_ST_RUN);
    assign bus.done = (state == MD_ST_DONE);
    assign bus.hi   = hi;
    assign bus.lo   = lo;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= MD_ST_IDLE;
        else        state <= state_n;
    end

    // Datapath registers: result, operand, op and step counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
            op_q <= 1'b0;
            cnt  <= '0;
        end else begin
            hi   <= hi_n;
            lo   <= lo_n;
            opnd <= opnd_n;
            op_q <= op_n;
            cnt  <= cnt_n;
        end
    end

    // Next state, iteration step and ALU drive
    always_comb begin
        state_n = state;
        hi_n    = hi;
        lo_n    = lo;
        opnd_n  = opnd;
        op_n    = op_q;
        cnt_n   = cnt;
        alu_c   = ALU_C_ADD;
        op1     = '0;
        op2     = '0;
        unique case (state)
            MD_ST_RUN: begin
                cnt_n = cnt + 1'b1;
                if (op_q == MD_OP_MULTU) begin
                    alu_c = ALU_C_ADD;
                    op1   = hi;
                    op2   = opnd;
                    if (lo[0])
                        {hi_n, lo_n} = {carry, alu_res, lo[WIDTH-1:1]};
                    else
                        {hi_n, lo_n} = {1'b0, hi, lo[WIDTH-1:1]};
                end else begin
                    alu_c = ALU_C_SUB;
                    op1   = r;
                    op2   = opnd;
                    if (hi[WIDTH-1] || (r >= opnd)) begin
                        hi_n = alu_res;
                        lo_n = {lo[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_n = r;
                        lo_n = {lo[WIDTH-2:0], 1'b0};
                    end
                end
                if (cnt == CNT_W'(WIDTH - 1))
                    state_n = MD_ST_DONE;
            end
            default: begin
                if (bus.start) begin
                    op_n  = bus.op;
                    cnt_n = '0;
                    if (bus.op == MD_OP_MULTU) begin
                        hi_n    = '0;
                        lo_n    = bus.b;
                        opnd_n  = bus.a;
                        state_n = MD_ST_RUN;
                    end else if (bus.b != '0) begin
                        hi_n    = '0;
                        lo_n    = bus.a;
                        opnd_n  = bus.b;
                        state_n = MD_ST_RUN;
                    end else begin
                        hi_n    = bus.a;
                        lo_n    = '1;
                        state_n = MD_ST_DONE;
                    end
                end else if (state == MD_ST_DONE) begin
                    state_n = MD_ST_IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq.
// Arithmetic reference model plus directed literals.
module tb_muldiv_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        if (o == 1'b0) return 64'(x) * 64'(y);
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
    endfunction

    // Reference model: busy lasts 32 steps, then one done cycle
    bit          en = 0;
    bit          m_busy, m_done;
    int          m_rem;
    logic [63:0] m_res, pend;

    always @(posedge clk) begin
        en = 1;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_rem = 0; m_res = '0;
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 0; m_done = 1; m_res = pend;
            end
        end else if (bus.start) begin
            pend = ref_res(bus.op, bus.a, bus.b);
            if (bus.op && bus.b == 32'd0) begin
                m_done = 1; m_res = pend;
            end else begin
                m_busy = 1; m_done = 0; m_rem = 32;
            end
        end else begin
            m_done = 0;
        end
    end

    // Compare DUT against model every cycle
    always @(negedge clk) begin
        if (en) begin
            chk("busy", 64'(bus.busy), 64'(m_busy));
            chk("done", 64'(bus.done), 64'(m_done));
            if (!m_busy) chk("hilo", {bus.hi, bus.lo}, m_res);
        end
    end

    task automatic issue(input logic o, input logic [31:0] x,
                         input logic [31:0] y);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    endtask

    task automatic wait_done(input string nm, input int lat,
                             input logic [63:0] exp, input bit noise);
        int n = 0;
        while (n < 80) begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
            if (bus.done) break;
            if (noise && $urandom_range(0, 7) == 0) begin
                bus.start = 1'b1;
                bus.op = 1'($urandom_range(0, 1));
                bus.a = $urandom; bus.b = $urandom;
            end
        end
        chk({nm, " latency"}, 64'(n), 64'(lat));
        chk({nm, " result"}, {bus.hi, bus.lo}, exp);
    endtask

    task automatic req(input string nm, input logic o,
                       input logic [31:0] x, input logic [31:0] y,
                       input int lat, input logic [63:0] exp);
        @(negedge clk);
        issue(o, x, y);
        wait_done(nm, lat, exp, 0);
    endtask

    initial begin
        int dn;
        logic o;
        logic [31:0] x, y;
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        req("mul_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33,
            64'hFFFFFFFE_00000001);
        req("div_100_7", 1'b1, 32'd100, 32'd7, 33, {32'd2, 32'd14});
        req("div_8m_3", 1'b1, 32'h80000000, 32'd3, 33,
            {32'd2, 32'h2AAAAAAA});
        req("div_zero", 1'b1, 32'h12345678, 32'd0, 1,
            {32'h12345678, 32'hFFFFFFFF});
        req("div_zero2", 1'b1, 32'hCAFEF00D, 32'd0, 1,
            {32'hCAFEF00D, 32'hFFFFFFFF});

        @(negedge clk);
        issue(1'b0, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        issue(1'b1, 32'd99, 32'd5);
        wait_done("mul_ignore", 28, {32'd0, 32'd42}, 0);

        @(negedge clk);
        issue(1'b0, 32'd1234, 32'd5678);
        repeat (10) @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid busy", 64'(bus.busy), 64'd0);
        chk("rst_mid done", 64'(bus.done), 64'd0);
        chk("rst_mid hilo", {bus.hi, bus.lo}, 64'd0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("rst_mid no_done", 64'(dn), 64'd0);

        req("b2b_mul", 1'b0, 32'd3, 32'd5, 33, {32'd0, 32'd15});
        issue(1'b1, 32'd9, 32'd2);
        wait_done("b2b_div", 33, {32'd1, 32'd4}, 0);
        repeat (5) @(negedge clk);
        chk("b2b_hold", {bus.hi, bus.lo}, {32'd1, 32'd4});

        for (int i = 0; i < 30; i++) begin
            o = 1'($urandom_range(0, 1));
            x = $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 1) ? $urandom :
                 32'($urandom_range(1, 300)));
            @(negedge clk);
            issue(o, x, y);
            wait_done("rand", (o && y == 32'd0) ? 1 : 33,
                      ref_res(o, x, y), 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        issue(1'b0, $urandom, $urandom);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        issue(1'b1, 32'd50, 32'd3);
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b1;
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        chk("rst idle busy", 64'(bus.busy), 64'd0);
        chk("rst idle hilo", {bus.hi, bus.lo}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
